// File: rtl/imem_pkg.sv
// imem_pkg: shared constants, types and elaboration checks for the
// instruction memory (imem_rom) and its pipeline stage (imem_stage).
//   NOP             - canonical RISC-V no-op (addi x0,x0,0)
//   LATENCY_MAX     - deepest supported read pipeline
//   fault_e         - fault cause, kept internal for debug visibility
//   latency_legal() - elaboration-time range check for LATENCY
package imem_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int unsigned LATENCY_MAX = 4;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_MISALIGN = 2'd1,
    FAULT_RANGE    = 2'd2
  } fault_e;

  function automatic bit latency_legal(input int unsigned lat);
    return (lat >= 1) && (lat <= LATENCY_MAX);
  endfunction

endpackage

// File: rtl/imem_stage.sv
// imem_stage: one forwarding register of the instruction-memory read
// pipeline. Holds valid, addr, data and fault of one in-flight fetch.
//   clk, rst        - clock, asynchronous active-high reset
//   adv             - pipeline advance; when low the stage holds
//   kill            - branch redirect; clears valid regardless of adv
//   in_*            - contents of the previous stage
//   out_*           - contents of this stage
module imem_stage #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  input  logic              kill,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_fault,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_fault
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_fault <= 1'b0;
    end else if (kill) begin
      out_valid <= 1'b0;
    end else if (adv) begin
      out_valid <= in_valid;
      // Payload only moves with a live entry so idle slots stay quiet.
      if (in_valid) begin
        out_addr  <= in_addr;
        out_data  <= in_data;
        out_fault <= in_fault;
      end
    end
  end

endmodule

// File: rtl/imem_rom.sv
// imem_rom: parametrised instruction memory for the fetch stage.
// Synchronous array read into stage S1, followed by LATENCY-1 forwarding
// stages; the last stage drives the response. Valid/ready on both sides,
// flush kills everything in flight, misaligned / out-of-range requests
// return FILL_WORD with rsp_fault set. Each response carries its address.
//   clk, rst   - clock, asynchronous active-high reset
//   req_valid  - fetch request present
//   req_ready  - request accepted when req_valid is also high
//   req_addr   - byte address of the request
//   flush      - branch redirect; kills all in-flight requests
//   rsp_valid  - response present
//   rsp_ready  - consumer accepts the response
//   rsp_data   - instruction word
//   rsp_addr   - byte address the response belongs to
//   rsp_fault  - misaligned or out-of-range request
module imem_rom
  import imem_pkg::*;
#(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DEPTH_WORDS = 4096,
  parameter int unsigned       LATENCY     = 1,
  parameter string             INIT_FILE   = "",
  parameter logic [DATA_W-1:0] FILL_WORD   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_fault
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  if (!latency_legal(LATENCY)) begin : g_bad_latency
    $error("imem_rom: LATENCY must be in 1..%0d", LATENCY_MAX);
  end

  // ---------------------------------------------------------------------
  // Array: unloaded words read as FILL_WORD; reset never touches it.
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH_WORDS] = '{default: FILL_WORD};

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  logic adv;
  logic accept;

  assign adv       = !rsp_valid || rsp_ready;
  assign req_ready = adv || flush;
  assign accept    = req_valid && req_ready;

  // ---------------------------------------------------------------------
  // Request decode and fault classification
  // ---------------------------------------------------------------------
  logic             misalign;
  logic             out_of_range;
  logic             req_fault;
  logic [IDX_W-1:0] idx;
  fault_e           cause;

  assign misalign = |req_addr[1:0];
  assign idx      = req_addr[IDX_W+1:2];

  // Address bits above the array index only feed the range check.
  if (ADDR_W > IDX_W + 2) begin : g_range
    assign out_of_range = |req_addr[ADDR_W-1:IDX_W+2];
  end else begin : g_no_range
    assign out_of_range = 1'b0;
  end

  always_comb begin
    cause = FAULT_NONE;
    if (misalign) begin
      cause = FAULT_MISALIGN;
    end else if (out_of_range) begin
      cause = FAULT_RANGE;
    end
  end

  assign req_fault = (cause != FAULT_NONE);

  // ---------------------------------------------------------------------
  // Stage S1: array read. Loads whenever a request could be accepted
  // (advance, or flush overriding a stall); a flush with no request
  // leaves it empty.
  // ---------------------------------------------------------------------
  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr;
  logic [DATA_W-1:0] s1_data;
  logic              s1_fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_data  <= '0;
      s1_fault <= 1'b0;
    end else if (req_ready) begin
      s1_valid <= accept;
      if (accept) begin
        s1_addr  <= req_addr;
        s1_fault <= req_fault;
        if (req_fault) begin
          s1_data <= FILL_WORD;
        end else begin
          s1_data <= mem[idx];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stages S2..SL: element 0 is S1, element LATENCY-1 drives the response.
  // ---------------------------------------------------------------------
  logic              stg_valid [LATENCY];
  logic [ADDR_W-1:0] stg_addr  [LATENCY];
  logic [DATA_W-1:0] stg_data  [LATENCY];
  logic              stg_fault [LATENCY];

  assign stg_valid[0] = s1_valid;
  assign stg_addr[0]  = s1_addr;
  assign stg_data[0]  = s1_data;
  assign stg_fault[0] = s1_fault;

  for (genvar i = 1; i < LATENCY; i++) begin : g_stage
    imem_stage #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .adv      (adv),
      .kill     (flush),
      .in_valid (stg_valid[i-1]),
      .in_addr  (stg_addr[i-1]),
      .in_data  (stg_data[i-1]),
      .in_fault (stg_fault[i-1]),
      .out_valid(stg_valid[i]),
      .out_addr (stg_addr[i]),
      .out_data (stg_data[i]),
      .out_fault(stg_fault[i])
    );
  end

  assign rsp_valid = stg_valid[LATENCY-1];
  assign rsp_addr  = stg_addr[LATENCY-1];
  assign rsp_data  = stg_data[LATENCY-1];
  assign rsp_fault = stg_fault[LATENCY-1];

endmodule

// File: tb/tb_imem_rom.sv
// tb_imem_rom: self-checking bench for imem_rom. Two instances share all
// inputs: u3 (LATENCY=3) carries most scenarios, u1 (LATENCY=1) covers the
// single-cycle case and reset. Array contents are written hierarchically;
// the bench keeps its own copy and a queue-based reference of outstanding
// requests (accepted minus consumed, cleared on flush/reset).
module tb_imem_rom;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] FILL  = 32'h0BAD_F00D;
  localparam logic [31:0] W0    = 32'h0010_0113;
  localparam logic [31:0] W1    = 32'h0020_8663;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        fault;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        flush = 1'b0;
  logic        rsp_ready = 1'b0;

  logic        r3_req_ready, r3_rsp_valid, r3_rsp_fault;
  logic [31:0] r3_rsp_data, r3_rsp_addr;
  logic        r1_req_ready, r1_rsp_valid, r1_rsp_fault;
  logic [31:0] r1_rsp_data, r1_rsp_addr;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  logic last_acc = 1'b0;

  logic [31:0] ref_mem [DEPTH];
  rsp_t exp_q[$];
  rsp_t got_q[$];
  rsp_t want_q[$];

  imem_rom #(
    .DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(3),
    .INIT_FILE(""), .FILL_WORD(FILL)
  ) u3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r3_req_ready),
    .req_addr(req_addr), .flush(flush), .rsp_valid(r3_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(r3_rsp_data), .rsp_addr(r3_rsp_addr),
    .rsp_fault(r3_rsp_fault)
  );

  imem_rom #(
    .DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(1),
    .INIT_FILE(""), .FILL_WORD(FILL)
  ) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r1_req_ready),
    .req_addr(req_addr), .flush(flush), .rsp_valid(r1_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(r1_rsp_data), .rsp_addr(r1_rsp_addr),
    .rsp_fault(r1_rsp_fault)
  );

  always #5 clk = ~clk;

  // Expected response for a byte address, straight from the fault rules.
  function automatic rsp_t model_rsp(input logic [31:0] a);
    rsp_t r;
    r.addr  = a;
    r.fault = (a % 4 != 0) || (a / 4 >= DEPTH);
    r.data  = r.fault ? FILL : ref_mem[a[7:2]];
    return r;
  endfunction

  // One clock cycle: drive inputs after the edge, sample mid-cycle, and
  // update the outstanding-request reference for the u3 instance.
  task automatic cyc(input logic v, input logic [31:0] a, input logic fl,
                     input logic rr);
    rsp_t m;
    @(posedge clk);
    #1;
    req_valid = v;
    req_addr  = a;
    flush     = fl;
    rsp_ready = rr;
    #2;
    cycle++;
    last_acc = v && r3_req_ready;
    if (r3_rsp_valid && rr) begin
      got_q.push_back('{r3_rsp_addr, r3_rsp_data, r3_rsp_fault});
      if (exp_q.size() > 0) begin
        want_q.push_back(exp_q.pop_front());
      end else begin
        m = 'x;
        want_q.push_back(m);
      end
    end
    if (fl) exp_q.delete();
    if (last_acc) exp_q.push_back(model_rsp(a));
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({r3_rsp_valid, r3_rsp_data, r3_rsp_addr, r3_rsp_fault} !== '0) begin
      errors++;
      $display("FAIL reset_u3 got valid=%b data=%h addr=%h fault=%b expected all 0",
               r3_rsp_valid, r3_rsp_data, r3_rsp_addr, r3_rsp_fault);
    end
    checks++;
    if ({r1_rsp_valid, r1_rsp_data, r1_rsp_addr, r1_rsp_fault} !== '0) begin
      errors++;
      $display("FAIL reset_u1 got valid=%b data=%h addr=%h fault=%b expected all 0",
               r1_rsp_valid, r1_rsp_data, r1_rsp_addr, r1_rsp_fault);
    end
    checks++;
    if (r3_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b expected 1", r3_req_ready);
    end
    @(posedge clk);
    #4 rst = 1'b0;
  endtask

  task automatic test_lat1;
    cyc(1'b1, 32'd0, 1'b0, 1'b1);
    cyc(1'b1, 32'd4, 1'b0, 1'b1);
    checks++;
    if ({r1_rsp_valid, r1_rsp_addr, r1_rsp_data, r1_rsp_fault} !== {1'b1, 32'd0, W0, 1'b0}) begin
      errors++;
      $display("FAIL lat1_rsp0 got valid=%b addr=%h data=%h fault=%b expected 1/0/%h/0",
               r1_rsp_valid, r1_rsp_addr, r1_rsp_data, r1_rsp_fault, W0);
    end
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    checks++;
    if ({r1_rsp_valid, r1_rsp_addr, r1_rsp_data, r1_rsp_fault} !== {1'b1, 32'd4, W1, 1'b0}) begin
      errors++;
      $display("FAIL lat1_rsp1 got valid=%b addr=%h data=%h fault=%b expected 1/4/%h/0",
               r1_rsp_valid, r1_rsp_addr, r1_rsp_data, r1_rsp_fault, W1);
    end
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    checks++;
    if (r1_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat1_idle got valid=%b expected 0", r1_rsp_valid);
    end
    repeat (4) cyc(1'b0, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back;
    rsp_t seen[$];
    int   seen_cyc[$];
    int   first_acc;
    rsp_t e;
    first_acc = -100;
    for (int j = 0; j < 14; j++) begin
      if (j < 8) cyc(1'b1, 32'(4 * j), 1'b0, 1'b1);
      else       cyc(1'b0, 32'd0, 1'b0, 1'b1);
      if (j == 0 && last_acc) first_acc = cycle;
      if (r3_rsp_valid) begin
        seen.push_back('{r3_rsp_addr, r3_rsp_data, r3_rsp_fault});
        seen_cyc.push_back(cycle);
      end
    end
    checks++;
    if (seen_cyc.size() == 0 || seen_cyc[0] - first_acc != 3) begin
      errors++;
      $display("FAIL b2b_latency got %0d cycles expected 3",
               seen_cyc.size() == 0 ? -1 : seen_cyc[0] - first_acc);
    end
    checks++;
    if (seen.size() != 8) begin
      errors++;
      $display("FAIL b2b_count got %0d responses expected 8", seen.size());
    end
    for (int k = 0; k < 8 && k < seen.size(); k++) begin
      e = model_rsp(32'(4 * k));
      checks++;
      if (seen[k] !== e || seen_cyc[k] != seen_cyc[0] + k) begin
        errors++;
        $display("FAIL b2b_rsp[%0d] got addr=%h data=%h fault=%b cyc+%0d expected addr=%h data=%h fault=%b cyc+%0d",
                 k, seen[k].addr, seen[k].data, seen[k].fault, seen_cyc[k] - seen_cyc[0],
                 e.addr, e.data, e.fault, k);
      end
    end
  endtask

  task automatic test_stall;
    got_q.delete();
    want_q.delete();
    cyc(1'b1, 32'd32, 1'b0, 1'b1);
    cyc(1'b1, 32'd36, 1'b0, 1'b1);
    cyc(1'b1, 32'd40, 1'b0, 1'b1);
    for (int j = 0; j < 4; j++) begin
      cyc(1'b1, 32'd44, 1'b0, 1'b0);
      checks++;
      if (exp_q.size() == 0 || r3_rsp_valid !== 1'b1 || r3_req_ready !== 1'b0 ||
          r3_rsp_addr !== exp_q[0].addr || r3_rsp_data !== exp_q[0].data) begin
        errors++;
        $display("FAIL stall[%0d] got valid=%b ready=%b addr=%h data=%h expected 1/0/%h/%h",
                 j, r3_rsp_valid, r3_req_ready, r3_rsp_addr, r3_rsp_data,
                 exp_q.size() > 0 ? exp_q[0].addr : 32'hx,
                 exp_q.size() > 0 ? exp_q[0].data : 32'hx);
      end
    end
    repeat (6) cyc(1'b0, 32'd0, 1'b0, 1'b1);
    checks++;
    if (got_q.size() != 3) begin
      errors++;
      $display("FAIL stall_count got %0d responses expected 3", got_q.size());
    end
    for (int k = 0; k < got_q.size() && k < 3; k++) begin
      checks++;
      if (got_q[k] !== model_rsp(32'(32 + 4 * k))) begin
        errors++;
        $display("FAIL stall_rsp[%0d] got addr=%h data=%h expected addr=%h",
                 k, got_q[k].addr, got_q[k].data, 32 + 4 * k);
      end
    end
  endtask

  task automatic test_flush;
    rsp_t e;
    got_q.delete();
    want_q.delete();
    e = model_rsp(32'd24);
    cyc(1'b1, 32'd8, 1'b0, 1'b1);
    cyc(1'b1, 32'd12, 1'b0, 1'b1);
    cyc(1'b1, 32'd16, 1'b0, 1'b1);
    cyc(1'b1, 32'd24, 1'b1, 1'b0);
    checks++;
    if (r3_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_ready got %b expected 1", r3_req_ready);
    end
    for (int j = 1; j <= 6; j++) begin
      cyc(1'b0, 32'd0, 1'b0, 1'b1);
      checks++;
      if (j == 3) begin
        if ({r3_rsp_valid, r3_rsp_addr, r3_rsp_data, r3_rsp_fault} !== {1'b1, e}) begin
          errors++;
          $display("FAIL flush_target got valid=%b addr=%h data=%h expected 1/%h/%h",
                   r3_rsp_valid, r3_rsp_addr, r3_rsp_data, e.addr, e.data);
        end
      end else if (r3_rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_empty[%0d] got valid=%b addr=%h expected 0",
                 j, r3_rsp_valid, r3_rsp_addr);
      end
    end
    checks++;
    if (got_q.size() != 1 || got_q[0].addr !== 32'd24) begin
      errors++;
      $display("FAIL flush_only got %0d responses first addr=%h expected 1 at 00000018",
               got_q.size(), got_q.size() > 0 ? got_q[0].addr : 32'hx);
    end
  endtask

  task automatic test_faults;
    logic [31:0] addrs [4];
    rsp_t exp_r [4];
    addrs[0] = 32'd6;
    addrs[1] = 32'(DEPTH * 4);
    addrs[2] = 32'h8000_0000;
    addrs[3] = 32'd0;
    exp_r[0] = '{32'd6, FILL, 1'b1};
    exp_r[1] = '{32'(DEPTH * 4), FILL, 1'b1};
    exp_r[2] = '{32'h8000_0000, FILL, 1'b1};
    exp_r[3] = '{32'd0, W0, 1'b0};
    got_q.delete();
    want_q.delete();
    for (int k = 0; k < 4; k++) cyc(1'b1, addrs[k], 1'b0, 1'b1);
    repeat (5) cyc(1'b0, 32'd0, 1'b0, 1'b1);
    checks++;
    if (got_q.size() != 4) begin
      errors++;
      $display("FAIL fault_count got %0d responses expected 4", got_q.size());
    end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_r[k]) begin
        errors++;
        $display("FAIL fault_rsp[%0d] got addr=%h data=%h fault=%b expected addr=%h data=%h fault=%b",
                 k, got_q[k].addr, got_q[k].data, got_q[k].fault,
                 exp_r[k].addr, exp_r[k].data, exp_r[k].fault);
      end
    end
  endtask

  task automatic test_async_reset;
    cyc(1'b1, 32'd0, 1'b0, 1'b1);
    cyc(1'b1, 32'd4, 1'b0, 1'b1);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    checks++;
    if (r3_rsp_valid !== 1'b1 || r3_rsp_data !== W0) begin
      errors++;
      $display("FAIL arst_pre got valid=%b data=%h expected 1/%h", r3_rsp_valid, r3_rsp_data, W0);
    end
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    checks++;
    if ({r3_rsp_valid, r3_rsp_data, r3_rsp_addr, r3_rsp_fault} !== '0) begin
      errors++;
      $display("FAIL arst_u3 got valid=%b data=%h addr=%h fault=%b expected all 0",
               r3_rsp_valid, r3_rsp_data, r3_rsp_addr, r3_rsp_fault);
    end
    checks++;
    if ({r1_rsp_valid, r1_rsp_data, r1_rsp_addr, r1_rsp_fault} !== '0) begin
      errors++;
      $display("FAIL arst_u1 got valid=%b data=%h addr=%h fault=%b expected all 0",
               r1_rsp_valid, r1_rsp_data, r1_rsp_addr, r1_rsp_fault);
    end
    @(posedge clk);
    @(posedge clk);
    #4 rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      cyc(1'b0, 32'd0, 1'b0, 1'b1);
      checks++;
      if (r3_rsp_valid !== 1'b0 || r1_rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL arst_ghost[%0d] got u3 valid=%b u1 valid=%b expected 0/0",
                 j, r3_rsp_valid, r1_rsp_valid);
      end
    end
    cyc(1'b1, 32'd0, 1'b0, 1'b1);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    checks++;
    if ({r1_rsp_valid, r1_rsp_addr, r1_rsp_data, r1_rsp_fault} !== {1'b1, 32'd0, W0, 1'b0}) begin
      errors++;
      $display("FAIL arst_fresh_u1 got valid=%b addr=%h data=%h expected 1/0/%h",
               r1_rsp_valid, r1_rsp_addr, r1_rsp_data, W0);
    end
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    checks++;
    if ({r3_rsp_valid, r3_rsp_addr, r3_rsp_data, r3_rsp_fault} !== {1'b1, 32'd0, W0, 1'b0}) begin
      errors++;
      $display("FAIL arst_fresh_u3 got valid=%b addr=%h data=%h expected 1/0/%h",
               r3_rsp_valid, r3_rsp_addr, r3_rsp_data, W0);
    end
    repeat (3) cyc(1'b0, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic test_random;
    logic        v, fl, rr;
    logic [31:0] a;
    int unsigned sel;
    got_q.delete();
    want_q.delete();
    for (int n = 0; n < 400; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 15) == 0);
      rr  = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      else if (sel == 7) a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      else if (sel == 8) a = 32'($urandom_range(DEPTH, 4 * DEPTH)) << 2;
      else               a = $urandom;
      cyc(v, a, fl, rr);
      checks++;
      if (r3_req_ready !== (!r3_rsp_valid || rr || fl)) begin
        errors++;
        $display("FAIL rand_ready[%0d] got %b expected %b", n, r3_req_ready,
                 !r3_rsp_valid || rr || fl);
      end
    end
    repeat (6) cyc(1'b0, 32'd0, 1'b0, 1'b1);
    checks++;
    if (got_q.size() != want_q.size() || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_count got %0d responses (%0d left) expected %0d (0 left)",
               got_q.size(), exp_q.size(), want_q.size());
    end
    for (int k = 0; k < got_q.size() && k < want_q.size(); k++) begin
      checks++;
      if (got_q[k] !== want_q[k]) begin
        errors++;
        $display("FAIL rand_rsp[%0d] got addr=%h data=%h fault=%b expected addr=%h data=%h fault=%b",
                 k, got_q[k].addr, got_q[k].data, got_q[k].fault,
                 want_q[k].addr, want_q[k].data, want_q[k].fault);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    #1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
    ref_mem[0] = W0;
    ref_mem[1] = W1;
    for (int i = 0; i < DEPTH; i++) begin
      u3.mem[i] = ref_mem[i];
      u1.mem[i] = ref_mem[i];
    end
    test_reset;
    test_lat1;
    test_back_to_back;
    test_stall;
    test_flush;
    test_faults;
    test_async_reset;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
